hamm_rx_deser: RTL and testbench

HAMM_RX_DESER -- requirements
Module: hamm_rx_deser

---
 rtl/hamm_pkg.sv | 19 +
 rtl/hamm_rx_deser_if.sv | 16 +
 rtl/hamm_fifo.sv | 74 +++++++
 rtl/hamm_rx_deser.sv | 143 ++++++++++++++
 tb/tb_hamm_rx_deser.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/hamm_pkg.sv
// Shared definitions for the Hamming(7,4) serial receive path.
// Holds the receive FSM state type, the codeword length and the default
// statistics counter width used by hamm_rx_deser and hamm_fifo.
package hamm_pkg;

  // Number of data bits in a frame (one Hamming(7,4) codeword)
  localparam int unsigned FRAME_LEN = 7;

  // Default width of the frame/drop statistics counters
  localparam int unsigned CNT_W_DEF = 8;

  // Receive FSM: waiting for start bit, shifting data, sampling stop bit
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/hamm_rx_deser_if.sv
// Codeword stream from the deserializer to the downstream corrector.
//   d_hamm  : head-of-FIFO codeword
//   d_valid : d_hamm holds a valid codeword
//   d_ready : consumer accepts; a pop occurs when d_valid && d_ready
// master = producer (deserializer), slave = consumer (corrector).
interface hamm_rx_deser_if;
  import hamm_pkg::*;

  logic [FRAME_LEN-1:0] d_hamm;
  logic                 d_valid;
  logic                 d_ready;

  modport master (output d_hamm, output d_valid, input  d_ready);
  modport slave  (input  d_hamm, input  d_valid, output d_ready);

endinterface

// File: rtl/hamm_fifo.sv
// Small codeword FIFO, DEPTH x FRAME_LEN bits.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   push       : write push_data this cycle (caller guarantees space,
//                which includes "full but popping in the same cycle")
//   push_data  : codeword to store
//   full       : no free entry
//   rd_valid   : head entry valid
//   rd_ready   : consumer accepts head; pop = rd_valid && rd_ready
//   rd_data    : head entry, zero when empty
module hamm_fifo
  import hamm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [FRAME_LEN-1:0] push_data,
  output logic                 full,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [FRAME_LEN-1:0] rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FRAME_LEN-1:0] mem_q [DEPTH];
  logic [FRAME_LEN-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q,  count_d;
  logic                 pop;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  // Gated so the output reads zero whenever nothing is held
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Pointers wrap naturally because DEPTH is a power of two
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hamm_rx_deser.sv
// Serial receiver for Hamming(7,4) codewords.
// Frame: start bit 0, 7 data bits LSB first, stop bit 1; rx_in is only
// sampled on bit_en strobes. Good frames go into a small FIFO feeding the
// downstream corrector; codewords are passed through unmodified.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bit_en     : bit-time strobe
//   rx_in      : serial line, idles high
//   dout       : codeword stream (d_hamm / d_valid / d_ready)
//   frm_err    : one-cycle pulse on a bad stop bit
//   ovr_err    : sticky, set when a frame is dropped on a full FIFO
//   err_clr    : clears ovr_err (a simultaneous overrun wins)
//   frame_cnt  : frames pushed, saturating
//   drop_cnt   : frames dropped (framing or overrun), saturating
module hamm_rx_deser
  import hamm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_in,
  hamm_rx_deser_if.master   dout,
  output logic              frm_err,
  output logic              ovr_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  rx_state_e            state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic                 frm_err_q, frm_err_d;
  logic                 ovr_err_q, ovr_err_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic push, drop_frm, drop_ovr;
  logic fifo_full, pop, space;

  assign pop   = dout.d_valid && dout.d_ready;
  // A full FIFO still has room if its head leaves in the same cycle
  assign space = !fifo_full || pop;

  hamm_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .full      (fifo_full),
    .rd_valid  (dout.d_valid),
    .rd_ready  (dout.d_ready),
    .rd_data   (dout.d_hamm)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    drop_frm = 1'b0;
    drop_ovr = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_in) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = rx_in;
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!rx_in) begin
            drop_frm = 1'b1;
          end else if (space) begin
            push = 1'b1;
          end else begin
            drop_ovr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    frm_err_d   = drop_frm;
    ovr_err_d   = ovr_err_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (err_clr) begin
      ovr_err_d = 1'b0;
    end
    if (drop_ovr) begin
      ovr_err_d = 1'b1;
    end
    if (push && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if ((drop_frm || drop_ovr) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      frm_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frm_err_q   <= frm_err_d;
      ovr_err_q   <= ovr_err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frm_err   = frm_err_q;
  assign ovr_err   = ovr_err_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_hamm_rx_deser.sv
// Directed bench for hamm_rx_deser: frames are driven serially, accepted
// codewords are queued as expectations and checked when the consumer pops.
module tb_hamm_rx_deser;
  import hamm_pkg::*;

  logic       clk = 1'b0;
  logic       rst, bit_en, rx_in, err_clr;
  logic       frm_err, ovr_err;
  logic [7:0] frame_cnt, drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [6:0]  exp_q[$];

  hamm_rx_deser_if dif ();

  hamm_rx_deser #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .rx_in     (rx_in),
    .dout      (dif),
    .frm_err   (frm_err),
    .ovr_err   (ovr_err),
    .err_clr   (err_clr),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: a pop happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && dif.d_valid === 1'b1 && dif.d_ready === 1'b1) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_codeword", 32'(dif.d_hamm), 32'(exp_q.pop_front()));
      end
    end
  end

  // Sends start, 7 data bits LSB first, stop. div-1 glitch cycles with
  // bit_en=0 precede every strobe. Returns 1 time unit after the stop edge.
  task automatic send_frame(input logic [6:0] cw, input logic stop,
                            input int unsigned div, input logic ready_at_stop);
    logic [8:0] bits;
    bits = {stop, cw, 1'b0};
    for (int i = 0; i < 9; i++) begin
      for (int unsigned k = 1; k < div; k++) begin
        bit_en = 1'b0;
        rx_in  = 1'($urandom);
        @(posedge clk); #1;
      end
      bit_en = 1'b1;
      rx_in  = bits[i];
      if (i == 8 && ready_at_stop) dif.d_ready = 1'b1;
      @(posedge clk); #1;
    end
    bit_en = 1'b0;
    rx_in  = 1'b1;
    if (ready_at_stop) dif.d_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1; err_clr = 1'b0; dif.d_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_valid",   32'(dif.d_valid), 32'd0);
    check("rst_d_hamm",    32'(dif.d_hamm),  32'd0);
    check("rst_frm_err",   32'(frm_err),     32'd0);
    check("rst_ovr_err",   32'(ovr_err),     32'd0);
    check("rst_frame_cnt", 32'(frame_cnt),   32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean frame at full rate, consumer ready
    dif.d_ready = 1'b1;
    exp_q.push_back(7'h55);
    send_frame(7'h55, 1'b1, 1, 1'b0);
    check("good_d_valid",   32'(dif.d_valid), 32'd1);
    check("good_d_hamm",    32'(dif.d_hamm),  32'h55);
    check("good_frame_cnt", 32'(frame_cnt),   32'd1);
    check("good_frm_err",   32'(frm_err),     32'd0);
    @(posedge clk); #1;
    check("good_popped",    32'(dif.d_valid), 32'd0);

    // Bad stop bit
    send_frame(7'h55, 1'b0, 1, 1'b0);
    check("frm_pulse",     32'(frm_err),     32'd1);
    check("frm_no_valid",  32'(dif.d_valid), 32'd0);
    check("frm_drop_cnt",  32'(drop_cnt),    32'd1);
    @(posedge clk); #1;
    check("frm_pulse_end", 32'(frm_err),     32'd0);
    check("frm_no_valid2", 32'(dif.d_valid), 32'd0);

    // Overrun: consumer stalled, third frame dropped; err_clr held during
    // the overrun so the set must win
    dif.d_ready = 1'b0;
    exp_q.push_back(7'h01);
    send_frame(7'h01, 1'b1, 1, 1'b0);
    exp_q.push_back(7'h02);
    send_frame(7'h02, 1'b1, 1, 1'b0);
    err_clr = 1'b1;
    send_frame(7'h03, 1'b1, 1, 1'b0);
    err_clr = 1'b0;
    check("ovr_set",       32'(ovr_err),     32'd1);
    check("ovr_drop_cnt",  32'(drop_cnt),    32'd2);
    check("ovr_frame_cnt", 32'(frame_cnt),   32'd3);
    check("ovr_head",      32'(dif.d_hamm),  32'h01);
    check("ovr_valid",     32'(dif.d_valid), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ovr_cleared",   32'(ovr_err),     32'd0);
    check("ovr_hold_head", 32'(dif.d_hamm),  32'h01);

    // Full FIFO, pop coincides with the stop sample: push accepted
    exp_q.push_back(7'h04);
    send_frame(7'h04, 1'b1, 1, 1'b1);
    check("fullpop_ovr",       32'(ovr_err),     32'd0);
    check("fullpop_frame_cnt", 32'(frame_cnt),   32'd4);
    check("fullpop_drop_cnt",  32'(drop_cnt),    32'd2);
    check("fullpop_head",      32'(dif.d_hamm),  32'h02);
    check("fullpop_valid",     32'(dif.d_valid), 32'd1);
    dif.d_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid",    32'(dif.d_valid),  32'd0);

    // Reset mid-frame (start + 4 data bits); line still active during rst
    bit_en = 1'b1;
    rx_in  = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'(i & 1);
      @(posedge clk); #1;
    end
    rst   = 1'b1;
    rx_in = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    check("midrst_frame_cnt", 32'(frame_cnt),   32'd0);
    check("midrst_drop_cnt",  32'(drop_cnt),    32'd0);
    check("midrst_valid",     32'(dif.d_valid), 32'd0);
    check("midrst_frm_err",   32'(frm_err),     32'd0);
    exp_q.push_back(7'h2A);
    send_frame(7'h2A, 1'b1, 1, 1'b0);
    check("midrst_d_hamm",    32'(dif.d_hamm),  32'h2A);
    check("midrst_frame_1",   32'(frame_cnt),   32'd1);
    check("midrst_drop_0",    32'(drop_cnt),    32'd0);
    @(posedge clk); #1;

    // Quarter-rate strobes with glitches between them
    exp_q.push_back(7'h7F);
    send_frame(7'h7F, 1'b1, 4, 1'b0);
    check("slow_d_valid",   32'(dif.d_valid), 32'd1);
    check("slow_d_hamm",    32'(dif.d_hamm),  32'h7F);
    check("slow_frame_cnt", 32'(frame_cnt),   32'd2);
    check("slow_frm_err",   32'(frm_err),     32'd0);
    @(posedge clk); #1;
    check("slow_popped",    32'(dif.d_valid), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
